// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// opcode constants, mux-select encodings and the control output bundle.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ_EX   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP_EX  = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // Raw per-state control bundle. Fields that depend on mem_ready are
    // gated in the top level; rdy_gate marks that pc_write waits on memory.
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       branch;
        logic       rdy_gate;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_out_dec.sv
// State-to-control decoder: pure Moore mapping from the state register to
// the raw control bundle (memory handshake gating happens in mc_ctrl).
module mc_out_dec
    import mc_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Per-state control values; anything not set stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCS_ALU;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.rdy_gate  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
            end
            S_RTYPE_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RTYPE_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_BEQ_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCS_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            S_JUMP_EX: begin
                ctrl.pc_source = PCS_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-style control unit: state register, next-state logic and
// memory-handshake / branch gating of the decoded control bundle.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter logic MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic       illegal
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   rdy;
    logic   pc_write;

    // With waiting disabled every memory access completes in one cycle.
    assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    mc_out_dec u_out_dec (
        .state (state),
        .ctrl  (ctrl)
    );

    // State register; reset wins from any state, including a memory wait.
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Next-state selection from current state, opcode and memory handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    state_nxt = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_RTYPE_EX;
                    OP_BEQ:       state_nxt = S_BEQ_EX;
                    OP_ADDI:      state_nxt = S_ADDI_EX;
                    OP_J:         state_nxt = S_JUMP_EX;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_nxt = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_nxt = rdy ? S_FETCH : S_MEMWR;
            S_MEMWB:    state_nxt = S_FETCH;
            S_RTYPE_EX: state_nxt = S_RTYPE_WB;
            S_RTYPE_WB: state_nxt = S_FETCH;
            S_BEQ_EX:   state_nxt = S_FETCH;
            S_ADDI_EX:  state_nxt = S_ADDI_WB;
            S_ADDI_WB:  state_nxt = S_FETCH;
            S_JUMP_EX:  state_nxt = S_FETCH;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Output stage: enables wait on memory, branch qualifies on zero,
    // and everything is held low while reset is asserted.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        pc_write   = 1'b0;
        pc_en      = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            mem_req    = ctrl.mem_req;
            iord       = ctrl.iord;
            mem_write  = ctrl.mem_write & rdy;
            ir_write   = ctrl.ir_write & rdy;
            reg_write  = ctrl.reg_write;
            reg_dst    = ctrl.reg_dst;
            mem_to_reg = ctrl.mem_to_reg;
            alu_src_a  = ctrl.alu_src_a;
            alu_src_b  = ctrl.alu_src_b;
            alu_op     = ctrl.alu_op;
            pc_source  = ctrl.pc_source;
            pc_write   = ctrl.pc_write & (rdy | ~ctrl.rdy_gate);
            pc_en      = pc_write | (ctrl.branch & zero);
            illegal    = (state == S_DECODE) & ~is_legal_op(opcode);
        end
    end

endmodule
